// File: rtl/uart_rx_fifo.sv
// UART receiver with x16 oversampling, optional parity, a receive FIFO
// and a four-register memory-mapped bus interface (DATA, STATUS, CONFIG).
module uart_rx_fifo #(
    parameter logic [15:0] DIV_DEFAULT = 16'd26,
    parameter int unsigned DATA_BITS   = 8,
    parameter bit          PARITY_EN   = 1'b0,
    parameter bit          PARITY_ODD  = 1'b0,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic        serial_in,
    output logic        irq
);

    localparam int unsigned EW = DATA_BITS + 2;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                 sync1_q, sync2_q, prev_q;
    logic [15:0]          baud_q;
    logic [15:0]          div_q;
    logic                 irq_en_q;
    logic                 tick;
    state_t               state_q;
    logic [3:0]           smp_q;
    logic [2:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_q;
    logic                 push;
    logic [EW-1:0]        push_entry;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 empty, full, pop, do_push, drop;
    logic                 ovr_q, ferr_q, perr_sticky_q;
    logic                 ready_q;
    logic [1:0]           reg_sel;
    logic                 bus_act, bus_wr, bus_rd;
    logic                 stat_wr, cfg_wr, div_wr;
    logic                 irq_q;
    logic [EW-1:0]        head;
    logic [7:0]           head_data;
    logic [31:0]          rdata;
    logic                 unused_bits;

    assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:17]};

    // ------------------------------------------------------------------
    // Bus decode: the access is performed in the single mem_ready cycle
    // ------------------------------------------------------------------
    assign reg_sel = mem_addr[3:2];
    assign bus_act = ready_q & enable;
    assign bus_wr  = bus_act & (|mem_wstrb);
    assign bus_rd  = bus_act & ~(|mem_wstrb);
    assign stat_wr = bus_wr & (reg_sel == 2'd1) & mem_wstrb[0];
    assign cfg_wr  = bus_wr & (reg_sel == 2'd2);
    assign div_wr  = cfg_wr & (mem_wstrb[0] | mem_wstrb[1]);

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Baud tick generator, restarted whenever the divider is written
    assign tick = (baud_q == div_q);

    always_ff @(posedge clk) begin
        if (reset || div_wr || tick) begin
            baud_q <= '0;
        end else begin
            baud_q <= baud_q + 16'd1;
        end
    end

    // Receive FSM: start validation, data shift, optional parity, stop
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            smp_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= S_START;
                        smp_q   <= '0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (smp_q == 4'd7) begin
                            smp_q   <= '0;
                            bit_q   <= '0;
                            state_q <= sync2_q ? S_IDLE : S_DATA;
                        end else begin
                            smp_q <= smp_q + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (smp_q == 4'd15) begin
                            smp_q   <= '0;
                            shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
                            if (bit_q == LAST_BIT) begin
                                state_q <= PARITY_EN ? S_PARITY : S_STOP;
                            end else begin
                                bit_q <= bit_q + 3'd1;
                            end
                        end else begin
                            smp_q <= smp_q + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        if (smp_q == 4'd15) begin
                            smp_q   <= '0;
                            perr_q  <= ((^shift_q) ^ sync2_q) != PARITY_ODD;
                            state_q <= S_STOP;
                        end else begin
                            smp_q <= smp_q + 4'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (smp_q == 4'd15) begin
                            smp_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            smp_q <= smp_q + 4'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The character is pushed in the same cycle the stop bit is sampled
    assign push       = (state_q == S_STOP) && tick && (smp_q == 4'd15);
    assign push_entry = {perr_q, ~sync2_q, shift_q};

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = bus_rd & (reg_sel == 2'd0) & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push = push & (~full | pop);
    assign drop    = push & full & ~pop;
    assign head    = mem_q[rd_ptr_q];

    // FIFO storage
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags: write-1-to-clear, a same-cycle set takes priority
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_q         <= 1'b0;
            ferr_q        <= 1'b0;
            perr_sticky_q <= 1'b0;
        end else begin
            ovr_q         <= (ovr_q & ~(stat_wr & mem_wdata[2])) | drop;
            ferr_q        <= (ferr_q & ~(stat_wr & mem_wdata[3])) | (push & ~sync2_q);
            perr_sticky_q <= (perr_sticky_q & ~(stat_wr & mem_wdata[4])) | (push & perr_q);
        end
    end

    // CONFIG register
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= DIV_DEFAULT;
            irq_en_q <= 1'b0;
        end else if (cfg_wr) begin
            if (mem_wstrb[0]) div_q[7:0]  <= mem_wdata[7:0];
            if (mem_wstrb[1]) div_q[15:8] <= mem_wdata[15:8];
            if (mem_wstrb[2]) irq_en_q    <= mem_wdata[16];
        end
    end

    // Bus handshake and registered interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            ready_q <= mem_valid & enable & ~ready_q;
            irq_q   <= irq_en_q & (~empty | ovr_q);
        end
    end

    // Read data mux, driven only while the access is acknowledged
    always_comb begin
        head_data = '0;
        head_data[DATA_BITS-1:0] = head[DATA_BITS-1:0];
        rdata = '0;
        if (bus_act) begin
            case (reg_sel)
                2'd0: if (!empty) rdata = {21'b0, head[EW-1], head[EW-2], 1'b1, head_data};
                2'd1: rdata = {8'b0, 8'(count_q), 11'b0, perr_sticky_q, ferr_q, ovr_q, full, ~empty};
                2'd2: rdata = {15'b0, irq_en_q, div_q};
                default: rdata = '0;
            endcase
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata;
    assign irq       = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: two instances (8N1 and 8E1), DIV=3,
// FIFO depth 4. Bus accesses queue their expected read data; a monitor
// compares whenever an instance acknowledges.
module tb_uart_rx_fifo;

    localparam int unsigned BIT = 64;  // (3+1) * 16 clk per bit

    typedef struct {
        int unsigned sel;
        logic        chk;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en0, en1, mem_valid;
    logic [3:0]  wstrb;
    logic [31:0] wdata, addr;
    logic        rx0, rx1;
    logic        rdy0, rdy1, irq0, irq1;
    logic [31:0] rd0, rd1;

    exp_t        exp_q[$];
    exp_t        me;
    int          errors = 0;
    int          checks = 0;
    logic        prev_rdy[2];
    logic        mr;
    logic [31:0] md;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DIV_DEFAULT(16'd3), .DATA_BITS(8), .PARITY_EN(1'b0),
        .PARITY_ODD(1'b0), .FIFO_DEPTH(4)
    ) dut0 (
        .clk(clk), .reset(reset), .enable(en0), .mem_valid(mem_valid),
        .mem_ready(rdy0), .mem_wstrb(wstrb), .mem_wdata(wdata),
        .mem_addr(addr), .mem_rdata(rd0), .serial_in(rx0), .irq(irq0)
    );

    uart_rx_fifo #(
        .DIV_DEFAULT(16'd3), .DATA_BITS(8), .PARITY_EN(1'b1),
        .PARITY_ODD(1'b0), .FIFO_DEPTH(4)
    ) dut1 (
        .clk(clk), .reset(reset), .enable(en1), .mem_valid(mem_valid),
        .mem_ready(rdy1), .mem_wstrb(wstrb), .mem_wdata(wdata),
        .mem_addr(addr), .mem_rdata(rd1), .serial_in(rx1), .irq(irq1)
    );

    // Monitor: every acknowledge pops one scoreboard entry
    initial begin
        prev_rdy[0] = 1'b0;
        prev_rdy[1] = 1'b0;
    end

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            mr = (s == 0) ? rdy0 : rdy1;
            md = (s == 0) ? rd0 : rd1;
            if (mr) begin
                if (prev_rdy[s]) begin
                    checks++; errors++;
                    $display("FAIL ready_pulse: block %0d mem_ready high 2 cycles, required 1", s);
                end else if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready: block %0d acknowledged with no request", s);
                end else begin
                    me = exp_q.pop_front();
                    if (me.sel != s) begin
                        checks++; errors++;
                        $display("FAIL %s: acknowledged by block %0d, required %0d", me.name, s, me.sel);
                    end else if (me.chk) begin
                        checks++;
                        if (md !== me.val) begin
                            errors++;
                            $display("FAIL %s: got 0x%08h expected 0x%08h", me.name, md, me.val);
                        end
                    end
                end
            end
            prev_rdy[s] = mr;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
        end
    endtask

    // One bus access; caller is aligned 1 time unit after a rising edge
    task automatic bus(input int unsigned sel, input logic [1:0] rsel, input logic [3:0] strb,
                       input logic [31:0] wd, input logic chk, input logic [31:0] exp_v,
                       input string name, output logic [31:0] got);
        exp_t e;
        logic done;
        e.sel = sel; e.chk = chk; e.val = exp_v; e.name = name;
        exp_q.push_back(e);
        addr  = {4'hA, 24'h0, rsel, 2'b01};
        wstrb = strb;
        wdata = wd;
        mem_valid = 1'b1;
        if (sel == 0) en0 = 1'b1; else en1 = 1'b1;
        got  = '0;
        done = 1'b0;
        for (int i = 0; i < 6 && !done; i++) begin
            @(negedge clk);
            if ((sel == 0) ? rdy0 : rdy1) begin
                done = 1'b1;
                got  = (sel == 0) ? rd0 : rd1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s: no mem_ready within 6 cycles", name);
            void'(exp_q.pop_back());
        end
        @(posedge clk); #1;
        mem_valid = 1'b0; en0 = 1'b0; en1 = 1'b0; wstrb = '0;
    endtask

    task automatic rd(input int unsigned sel, input logic [1:0] rsel,
                      input logic [31:0] exp_v, input string name);
        logic [31:0] g;
        bus(sel, rsel, 4'h0, 32'h0, 1'b1, exp_v, name, g);
    endtask

    task automatic wr(input int unsigned sel, input logic [1:0] rsel,
                      input logic [31:0] d, input string name);
        logic [31:0] g;
        bus(sel, rsel, 4'hF, d, 1'b0, 32'h0, name, g);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int unsigned sel, input logic v);
        if (sel == 0) rx0 = v; else rx1 = v;
        idle(BIT);
    endtask

    task automatic send(input int unsigned sel, input logic [7:0] d, input logic has_par,
                        input logic par, input logic stop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (has_par) drive_bit(sel, par);
        drive_bit(sel, stop);
        if (sel == 0) rx0 = 1'b1; else rx1 = 1'b1;
    endtask

    // Fixed tick phase (divider rewrite), then frame 0x25 with a DATA read
    // issued k cycles after the stop bit begins on the line
    task automatic trial(input int unsigned k, output logic [31:0] got);
        logic [31:0] g;
        wr(0, 2'd2, 32'h0000_0003, "trial_cfg");
        fork
            send(0, 8'h25, 1'b0, 1'b0, 1'b1);
            begin
                idle(9 * BIT + k);
                bus(0, 2'd0, 4'h0, 32'h0, 1'b0, 32'h0, "trial_rd", g);
            end
        join
        got = g;
        idle(4);
    endtask

    initial begin
        logic [31:0] g;
        int unsigned lo, hi, mid;
        reset = 1'b1; en0 = 1'b0; en1 = 1'b0; mem_valid = 1'b0;
        wstrb = '0; wdata = '0; addr = '0; rx0 = 1'b1; rx1 = 1'b1;
        idle(4);
        reset = 1'b0;
        idle(1);

        // Reset state
        check("irq_reset", {31'b0, irq0}, 32'h0);
        rd(0, 2'd1, 32'h0000_0000, "status_reset");
        rd(0, 2'd0, 32'h0000_0000, "data_reset");
        rd(0, 2'd2, 32'h0000_0003, "config_reset");
        rd(0, 2'd3, 32'h0000_0000, "reg3_reset");
        wr(0, 2'd3, 32'hFFFF_FFFF, "reg3_wr");
        rd(0, 2'd3, 32'h0000_0000, "reg3_after_wr");

        // Single 8N1 frame
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        idle(8);
        rd(0, 2'd1, 32'h0001_0001, "status_a5");
        rd(0, 2'd0, 32'h0000_01A5, "data_a5");
        rd(0, 2'd0, 32'h0000_0000, "data_empty");

        // Interrupt enable
        wr(0, 2'd2, 32'h0001_0003, "cfg_irq_en");
        rd(0, 2'd2, 32'h0001_0003, "cfg_readback");
        check("irq_empty", {31'b0, irq0}, 32'h0);
        send(0, 8'h11, 1'b0, 1'b0, 1'b1);
        check("irq_after_push", {31'b0, irq0}, 32'h1);
        rd(0, 2'd0, 32'h0000_0111, "data_11");
        idle(2);
        check("irq_after_pop", {31'b0, irq0}, 32'h0);
        wr(0, 2'd2, 32'h0000_0003, "cfg_irq_off");

        // Overflow with depth 4
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0, 1'b0, 1'b1);
        idle(8);
        rd(0, 2'd1, 32'h0004_0007, "status_ovr");
        check("irq_disabled", {31'b0, irq0}, 32'h0);
        for (int i = 1; i <= 4; i++) rd(0, 2'd0, 32'h100 + 32'(i), "data_ovr_seq");
        rd(0, 2'd1, 32'h0000_0004, "status_ovr_sticky");
        wr(0, 2'd1, 32'h0000_0004, "status_clr_ovr");
        rd(0, 2'd1, 32'h0000_0000, "status_ovr_cleared");

        // Frame error
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle(2 * BIT);
        rd(0, 2'd1, 32'h0001_0009, "status_ferr");
        rd(0, 2'd0, 32'h0000_033C, "data_ferr");
        send(0, 8'h55, 1'b0, 1'b0, 1'b1);
        idle(8);
        rd(0, 2'd0, 32'h0000_0155, "data_55");
        rd(0, 2'd1, 32'h0000_0008, "status_ferr_sticky");
        wr(0, 2'd1, 32'h0000_0008, "status_clr_ferr");
        rd(0, 2'd1, 32'h0000_0000, "status_ferr_cleared");

        // Start-bit glitch rejected, receiver still ready for a real frame
        rx0 = 1'b0;
        idle(20);
        rx0 = 1'b1;
        idle(3 * BIT);
        rd(0, 2'd1, 32'h0000_0000, "status_glitch");
        send(0, 8'h66, 1'b0, 1'b0, 1'b1);
        idle(8);
        rd(0, 2'd0, 32'h0000_0166, "data_after_glitch");

        // Reset in the middle of data bit 3 of 0xFF
        fork
            send(0, 8'hFF, 1'b0, 1'b0, 1'b1);
            begin
                idle(4 * BIT + BIT / 2);
                reset = 1'b1;
                idle(3);
                reset = 1'b0;
            end
        join
        idle(8);
        rd(0, 2'd1, 32'h0000_0000, "status_after_reset");
        send(0, 8'h12, 1'b0, 1'b0, 1'b1);
        idle(8);
        rd(0, 2'd0, 32'h0000_0112, "data_12");

        // Even parity on the second instance
        send(1, 8'h07, 1'b1, 1'b0, 1'b1);
        send(1, 8'h07, 1'b1, 1'b1, 1'b1);
        idle(8);
        rd(1, 2'd1, 32'h0002_0011, "par_status");
        rd(1, 2'd0, 32'h0000_0507, "par_bad");
        rd(1, 2'd0, 32'h0000_0107, "par_good");
        rd(1, 2'd1, 32'h0000_0010, "par_sticky");

        // Locate the read offset whose pop lands on the push edge: with an
        // empty FIFO that is the last offset still reading empty
        trial(0, g);
        check("sweep_early", g, 32'h0);
        rd(0, 2'd0, 32'h0000_0125, "sweep_drain");
        trial(63, g);
        check("sweep_late", g, 32'h0000_0125);
        lo = 0;
        hi = 63;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            trial(mid, g);
            if (g == 32'h0) begin
                lo = mid;
                rd(0, 2'd0, 32'h0000_0125, "sweep_drain");
            end else begin
                hi = mid;
                check("sweep_value", g, 32'h0000_0125);
            end
        end

        // Same offset with the FIFO full: pop and push both succeed
        for (int i = 1; i <= 4; i++) send(0, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b1);
        idle(8);
        rd(0, 2'd1, 32'h0004_0003, "full_status");
        trial(lo, g);
        check("coincide_pop", g, 32'h0000_0121);
        rd(0, 2'd1, 32'h0004_0003, "coincide_status");
        for (int i = 2; i <= 5; i++) rd(0, 2'd0, 32'h120 + 32'(i), "coincide_data");
        rd(0, 2'd1, 32'h0000_0000, "final_status");

        idle(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
